// File: rtl/dsp_equation_dispatch.sv
// Equation dispatcher: launches one of N_EQ engines, watches it with a
// saturating watchdog and muxes the selected engine's file port outward.
module dsp_equation_dispatch #(
  parameter int N_EQ           = 4,
  parameter int EQ_W           = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  input  logic                start,
  input  logic [EQ_W-1:0]     eq_num,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                interrupt,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [EQ_W-1:0]     active_eq,
  output logic [N_EQ-1:0]     eng_enable,
  output logic [N_EQ-1:0]     eng_start,
  input  logic [N_EQ-1:0]     eng_done,
  input  logic [N_EQ-1:0]     eng_error,
  input  logic [8*N_EQ-1:0]   eng_file_num,
  input  logic [N_EQ-1:0]     eng_file_write,
  input  logic [N_EQ-1:0]     eng_file_read,
  input  logic [N_EQ-1:0]     eng_file_reset,
  input  logic [32*N_EQ-1:0]  eng_file_write_data,
  output logic [7:0]          file_num,
  output logic                file_write,
  output logic                file_read,
  output logic                file_reset,
  output logic [31:0]         file_write_data
);

  localparam int SEL_W = (N_EQ > 1) ? $clog2(N_EQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = '1;
  localparam logic [EQ_W-1:0] EQ_MAX = EQ_W'(N_EQ);
  localparam logic [N_EQ-1:0] ONE    = N_EQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SEL_W-1:0]  r_sel;
  logic [WD_W-1:0]   r_wd;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic [EQ_W-1:0]   r_active_eq;

  logic              w_eq_ok;
  logic [SEL_W-1:0]  w_idx;
  logic              w_sel_done;
  logic              w_sel_err;
  logic [WD_W-1:0]   w_wd_inc;
  logic              w_wd_hit;
  logic              w_accept;
  logic              w_bad;
  logic              w_set_err;
  logic [1:0]        w_code;
  logic              w_busy;
  logic [N_EQ-1:0]   w_onehot;

  assign w_eq_ok    = (eq_num != '0) && (eq_num <= EQ_MAX);
  assign w_idx      = SEL_W'(eq_num - EQ_W'(1));
  assign w_sel_done = eng_done[r_sel];
  assign w_sel_err  = eng_error[r_sel];

  // Saturate so a disabled or very long watchdog never wraps to zero
  assign w_wd_inc = (r_wd == WD_MAX) ? r_wd : r_wd + WD_W'(1);
  assign w_wd_hit = (TIMEOUT_CYCLES != 0) && (w_wd_inc >= WD_LIM);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Priority in RUN: abort, engine error, engine done, watchdog
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_bad     = 1'b0;
    w_set_err = 1'b0;
    w_code    = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_eq_ok) begin
            w_next   = S_LAUNCH;
            w_accept = 1'b1;
          end else begin
            w_next    = S_ERROR;
            w_bad     = 1'b1;
            w_set_err = 1'b1;
            w_code    = 2'd1;
          end
        end
      end
      S_LAUNCH: begin
        w_next = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_sel_err) begin
          w_next    = S_ERROR;
          w_set_err = 1'b1;
          w_code    = 2'd3;
        end else if (w_sel_done) begin
          w_next = S_DONE;
        end else if (w_wd_hit) begin
          w_next    = S_ERROR;
          w_set_err = 1'b1;
          w_code    = 2'd2;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sel       <= '0;
      r_wd        <= '0;
      r_error     <= 1'b0;
      r_err_code  <= 2'd0;
      r_active_eq <= '0;
    end else begin
      if (w_accept) begin
        r_active_eq <= eq_num;
        r_sel       <= w_idx;
        r_error     <= 1'b0;
        r_err_code  <= 2'd0;
      end
      if (w_bad) begin
        r_active_eq <= eq_num;
      end
      if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_code <= w_code;
      end
      if (r_state == S_LAUNCH) begin
        r_wd <= '0;
      end else if (r_state == S_RUN) begin
        r_wd <= w_wd_inc;
      end
    end
  end

  assign w_busy   = (r_state == S_LAUNCH) || (r_state == S_RUN);
  assign w_onehot = ONE << r_sel;

  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign interrupt  = (r_state == S_DONE) || (r_state == S_ERROR);
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign active_eq  = r_active_eq;
  assign eng_enable = w_busy ? w_onehot : '0;
  assign eng_start  = (r_state == S_LAUNCH) ? w_onehot : '0;

  always_comb begin
    file_num        = 8'd0;
    file_write      = 1'b0;
    file_read       = 1'b0;
    file_reset      = 1'b0;
    file_write_data = 32'd0;
    if (w_busy) begin
      file_num        = eng_file_num[{r_sel, 3'b000} +: 8];
      file_write      = eng_file_write[r_sel];
      file_read       = eng_file_read[r_sel];
      file_reset      = eng_file_reset[r_sel];
      file_write_data = eng_file_write_data[{r_sel, 5'b00000} +: 32];
    end
  end

endmodule

// File: tb/tb_dsp_equation_dispatch.sv
// Scoreboard bench for dsp_equation_dispatch: a default-timeout instance for
// transactions and a TIMEOUT_CYCLES=8 instance for the watchdog path.
module tb_dsp_equation_dispatch;

  localparam int N  = 4;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, abort;
  logic [EW-1:0]   eq_num;
  logic            busy, done, irq, error;
  logic [1:0]      err_code;
  logic [EW-1:0]   active_eq;
  logic [N-1:0]    eng_enable, eng_start;
  logic [N-1:0]    eng_done, eng_error;
  logic [8*N-1:0]  efnum;
  logic [N-1:0]    efw, efr, efrst;
  logic [32*N-1:0] efwd;
  logic [7:0]      fnum;
  logic            fw, fr, frst;
  logic [31:0]     fwd;

  logic            w_start;
  logic [EW-1:0]   w_eq;
  logic            w_busy, w_done, w_irq, w_error;
  logic [1:0]      w_code;
  logic [EW-1:0]   w_aeq;
  logic [N-1:0]    w_en, w_st;
  logic [7:0]      w_fnum;
  logic            w_fw, w_fr, w_frst;
  logic [31:0]     w_fwd;

  dsp_equation_dispatch #(.N_EQ(N), .EQ_W(EW)) u_dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .start(start), .eq_num(eq_num), .abort(abort),
    .busy(busy), .done(done), .interrupt(irq),
    .error(error), .err_code(err_code), .active_eq(active_eq),
    .eng_enable(eng_enable), .eng_start(eng_start),
    .eng_done(eng_done), .eng_error(eng_error),
    .eng_file_num(efnum), .eng_file_write(efw),
    .eng_file_read(efr), .eng_file_reset(efrst),
    .eng_file_write_data(efwd),
    .file_num(fnum), .file_write(fw), .file_read(fr),
    .file_reset(frst), .file_write_data(fwd)
  );

  dsp_equation_dispatch #(
    .N_EQ(N), .EQ_W(EW), .TIMEOUT_CYCLES(8)
  ) u_wd (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .start(w_start), .eq_num(w_eq), .abort(1'b0),
    .busy(w_busy), .done(w_done), .interrupt(w_irq),
    .error(w_error), .err_code(w_code), .active_eq(w_aeq),
    .eng_enable(w_en), .eng_start(w_st),
    .eng_done(4'b0000), .eng_error(4'b0000),
    .eng_file_num(efnum), .eng_file_write(efw),
    .eng_file_read(efr), .eng_file_reset(efrst),
    .eng_file_write_data(efwd),
    .file_num(w_fnum), .file_write(w_fw), .file_read(w_fr),
    .file_reset(w_frst), .file_write_data(w_fwd)
  );

  typedef struct {
    logic [N-1:0] oh;
    int           cy;
  } st_t;

  typedef struct {
    logic          d;
    logic          e;
    logic [1:0]    c;
    logic [EW-1:0] a;
    int            cy;
  } ev_t;

  st_t q_st[$];
  ev_t q_ev[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  m_err = 1'b0;
  logic [1:0] m_code = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every engine launch and every interrupt must match the queue
  always @(negedge clk) begin
    st_t s;
    ev_t e;
    if (rst_n) begin
      if (eng_start != '0) begin
        if (q_st.size() == 0) begin
          chk("unexpected_eng_start", 64'(eng_start), 64'd0);
        end else begin
          s = q_st.pop_front();
          chk("eng_start", 64'(eng_start), 64'(s.oh));
          chk("eng_start_cycle", 64'(cyc), 64'(s.cy));
        end
      end
      if (irq || done) begin
        if (q_ev.size() == 0) begin
          chk("unexpected_irq", 64'({irq, done}), 64'd0);
        end else begin
          e = q_ev.pop_front();
          chk("event", 64'({irq, done, error, err_code, active_eq}),
              64'({1'b1, e.d, e.e, e.c, e.a}));
          chk("event_cycle", 64'(cyc), 64'(e.cy));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_files();
    efnum = $urandom;
    efwd  = {$urandom, $urandom, $urandom, $urandom};
    efw   = 4'($urandom);
    efr   = 4'($urandom);
    efrst = 4'($urandom);
  endtask

  // kind: 0 done, 1 error, 2 done+error same cycle, 3 abort
  task automatic run_txn(int eq, int kind, int lat, bit distract,
                         bit restart);
    logic [N-1:0] oh;
    logic [42:0]  fexp;
    int c, d, sel, oth;
    ev_t e;
    st_t s;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("err_sticky", 64'({error, err_code}), 64'({m_err, m_code}));
    rand_files();
    start  = 1'b1;
    eq_num = EW'(eq);
    c = cyc;
    tick();
    start = 1'b0;
    if (eq < 1 || eq > N) begin
      e = '{d: 1'b0, e: 1'b1, c: 2'd1, a: EW'(eq), cy: c + 1};
      q_ev.push_back(e);
      m_err  = 1'b1;
      m_code = 2'd1;
      tick(); tick(); tick();
      return;
    end
    sel = eq - 1;
    oth = (sel + 2) % N;
    oh  = N'(1 << sel);
    s = '{oh: oh, cy: c + 1};
    q_st.push_back(s);
    m_err  = 1'b0;
    m_code = 2'd0;
    d = c + 1 + lat;
    while (cyc < d) begin
      eng_done  = '0;
      eng_error = '0;
      start     = 1'b0;
      fexp = {efnum[sel*8 +: 8], efw[sel], efr[sel], efrst[sel],
              efwd[sel*32 +: 32]};
      chk("run_busy_en", 64'({busy, eng_enable}), 64'({1'b1, oh}));
      chk("file_mux", 64'({fnum, fw, fr, frst, fwd}), 64'(fexp));
      if (cyc == c + 2 && distract) begin
        eng_done  = N'(1 << oth);
        eng_error = N'(1 << ((oth + 1) % N == sel ? (oth + 2) % N
                                                 : (oth + 1) % N));
      end
      if (cyc == c + 2 && restart) begin
        start  = 1'b1;
        eq_num = EW'(oth + 1);
      end
      tick();
    end
    start     = 1'b0;
    eng_done  = '0;
    eng_error = '0;
    unique case (kind)
      0: begin
        eng_done = oh;
        e = '{d: 1'b1, e: 1'b0, c: 2'd0, a: EW'(eq), cy: d + 1};
        q_ev.push_back(e);
      end
      1, 2: begin
        eng_error = oh;
        if (kind == 2) eng_done = oh;
        e = '{d: 1'b0, e: 1'b1, c: 2'd3, a: EW'(eq), cy: d + 1};
        q_ev.push_back(e);
        m_err  = 1'b1;
        m_code = 2'd3;
      end
      default: abort = 1'b1;
    endcase
    tick();
    eng_done  = '0;
    eng_error = '0;
    abort     = 1'b0;
    chk("post_busy", 64'({busy, eng_enable, eng_start}), 64'd0);
    if (kind == 3) begin
      chk("abort_quiet", 64'({done, irq, fnum, fwd}), 64'd0);
    end
    tick(); tick();
  endtask

  task automatic reset_mid_run();
    st_t s;
    rand_files();
    start  = 1'b1;
    eq_num = 8'd3;
    s = '{oh: 4'b0100, cy: cyc + 1};
    q_st.push_back(s);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_run",
        64'({busy, done, irq, error, err_code, active_eq, eng_enable,
             eng_start, fnum, fw, fr, frst}), 64'd0);
    chk("reset_fwd", 64'(fwd), 64'd0);
    tick(); tick();
    rst_n  = 1'b1;
    m_err  = 1'b0;
    m_code = 2'd0;
    tick();
    chk("after_reset_idle", 64'({busy, irq, active_eq}), 64'd0);
  endtask

  task automatic watchdog_test();
    int c, seen;
    efnum = 32'h5A3C_96E1;
    chk("wd_reset_state",
        64'({w_busy, w_done, w_irq, w_error, w_code, w_aeq, w_en, w_st}),
        64'd0);
    w_start = 1'b1;
    w_eq    = 8'd1;
    c = cyc;
    tick();
    w_start = 1'b0;
    chk("wd_eng_start", 64'(w_st), 64'd1);
    seen = -1;
    for (int i = 0; i < 30 && seen < 0; i++) begin
      if (w_irq) begin
        seen = cyc;
      end else begin
        if (w_busy) chk("wd_file_mux", 64'(w_fnum), 64'h00E1);
        tick();
      end
    end
    chk("wd_irq_cycle", 64'(seen), 64'(c + 10));
    chk("wd_code", 64'({w_done, w_error, w_code, w_aeq}),
        64'({1'b0, 1'b1, 2'd2, 8'd1}));
    tick();
    chk("wd_file_zero",
        64'({w_busy, w_irq, w_fnum, w_fw, w_fr, w_frst, w_fwd}), 64'd0);
    chk("wd_err_held", 64'({w_error, w_code}), 64'({1'b1, 2'd2}));
  endtask

  initial begin
    int eq, kind, lat;
    start = 1'b0; abort = 1'b0; eq_num = '0;
    eng_done = '0; eng_error = '0;
    w_start = 1'b0; w_eq = '0;
    rand_files();
    tick(); tick();
    chk("reset_state",
        64'({busy, done, irq, error, err_code, active_eq, eng_enable,
             eng_start, fnum, fw, fr, frst}), 64'd0);
    rst_n = 1'b1;
    tick();

    run_txn(2, 0, 10, 1'b0, 1'b0);
    run_txn(0, 0, 1, 1'b0, 1'b0);
    run_txn(5, 0, 1, 1'b0, 1'b0);
    watchdog_test();
    run_txn(1, 2, 4, 1'b0, 1'b0);
    run_txn(1, 0, 6, 1'b1, 1'b0);
    run_txn(3, 3, 5, 1'b0, 1'b1);
    run_txn(4, 3, 0, 1'b0, 1'b0);
    run_txn(2, 1, 3, 1'b1, 1'b1);
    reset_mid_run();

    for (int t = 0; t < 40; t++) begin
      eq   = $urandom_range(0, 6);
      kind = $urandom_range(0, 3);
      lat  = (kind == 3) ? $urandom_range(0, 8) : $urandom_range(1, 12);
      run_txn(eq, kind, lat, 1'($urandom), 1'($urandom));
    end

    tick(); tick(); tick();
    chk("start_queue_drained", 64'(q_st.size()), 64'd0);
    chk("event_queue_drained", 64'(q_ev.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsp_equation_dispatch.md
DSP_EQUATION_DISPATCH -- requirements
Module: dsp_equation_dispatch

Interface
REQ-001 SHALL provide parameter N_EQ, default 4: number of equation engines (1..16).
REQ-002 SHALL provide parameter EQ_W, default 8: equation-number width.
REQ-003 SHALL provide parameter TIMEOUT_CYCLES, default 65535: RUN watchdog limit; 0 disables the watchdog.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, one per line (name, direction, width, meaning):
- wb_clk  in  1  clock
- wb_rst_n  in  1  async active-low reset
- start  in  1  launch request, sampled in IDLE only
- eq_num  in  EQ_W  requested equation, sampled with start
- abort  in  1  cancel the running equation
- busy  out  1  high in LAUNCH/RUN
- done  out  1  one-cycle completion pulse
- interrupt  out  1  one-cycle pulse on done or error
- error  out  1  sticky error flag
- err_code  out  2  0 none, 1 bad eq_num, 2 timeout, 3 engine error
- active_eq  out  EQ_W  latched equation number
- eng_enable  out  N_EQ  one-hot; selected engine held high in LAUNCH/RUN
- eng_start  out  N_EQ  one-hot one-cycle start pulse
- eng_done  in  N_EQ  per-engine done
- eng_error  in  N_EQ  per-engine error
- eng_file_num  in  8*N_EQ  per-engine file number, engine i at [8i+7:8i]
- eng_file_write / eng_file_read / eng_file_reset  in  N_EQ each  per-engine file strobes
- eng_file_write_data  in  32*N_EQ  per-engine write data
- file_num / file_write / file_read / file_reset / file_write_data  out  8/1/1/1/32  muxed file interface

Function
REQ-006 SHALL decode eq_num k, 1<=k<=N_EQ, to engine index k-1; eq_num 0 or >N_EQ is invalid.
REQ-007 SHALL implement FSM states IDLE, LAUNCH, RUN, DONE, ERROR.
REQ-008 IDLE: start with valid eq_num latches active_eq and sel, clears error/err_code, goes to LAUNCH.
REQ-009 IDLE: start with invalid eq_num latches active_eq, sets err_code=1, goes to ERROR.
REQ-010 LAUNCH: drives eng_start[sel]=1 for exactly one cycle, clears the watchdog counter, goes to RUN.
REQ-011 RUN: eng_error[sel] goes to ERROR with err_code=3.
REQ-012 RUN: eng_done[sel] goes to DONE; if eng_error[sel] is high in the same cycle, error wins.
REQ-013 RUN: the watchdog increments each cycle; reaching TIMEOUT_CYCLES without done goes to ERROR with err_code=2; done in that same cycle wins.
REQ-014 RUN or LAUNCH: abort returns to IDLE next cycle; no done, no interrupt, error unchanged; abort outranks every other RUN event.
REQ-015 DONE: done=1 and interrupt=1 for one cycle, then IDLE.
REQ-016 ERROR: error=1 (held until next accepted start), interrupt=1 for one cycle, then IDLE.
REQ-017 SHALL ignore start outside IDLE and ignore done/error of non-selected engines.
REQ-018 File outputs SHALL combinationally follow engine sel in LAUNCH/RUN and be all-zero otherwise.
REQ-019 The watchdog counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and saturate, never wrap.
REQ-020 Start-to-eng_start latency SHALL be 1 cycle; eng_done-to-done latency SHALL be 1 cycle.

Reset
REQ-021 wb_rst_n low SHALL force IDLE immediately, including mid-operation.
REQ-022 Reset SHALL zero all outputs: busy, done, interrupt, error, err_code, active_eq, eng_enable, eng_start, and the watchdog.

Verification
REQ-023 Bench: start, eq_num=2, N_EQ=4 -> eng_start=4'b0010 next cycle; eng_done[1] after 10 cycles -> done and interrupt pulse once; busy low after.
REQ-024 Bench: start, eq_num=0 and eq_num=5 -> no eng_start, error=1, err_code=1, one interrupt pulse.
REQ-025 Bench: TIMEOUT_CYCLES=8, eng_done never asserted -> err_code=2 after 8 RUN cycles; file outputs zero afterwards.
REQ-026 Bench: eng_done[0] and eng_error[0] in same cycle -> err_code=3, no done pulse; eng_done[2] while engine 0 selected -> ignored.
REQ-027 Bench: abort during RUN, then wb_rst_n low mid-RUN -> each returns IDLE, all outputs 0, no interrupt; a second start while busy -> ignored.
